// File: rtl/track_lock_ctrl.sv
// track_lock_ctrl: per-frame lock sequencer placed after the colour-blob tracker.
// It filters detections and produces a smoothed centre, a clamped box and a signed steering error.
module track_lock_ctrl #(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int ACQ_FRAMES  = 3,
  parameter int LOST_FRAMES = 8,
  parameter int MAX_JUMP    = 64,
  parameter int MIN_SIZE    = 4
) (
  input  logic        clock_50,
  input  logic        reset,
  input  logic        enable,
  input  logic        frame_done,
  input  logic        det_valid,
  input  logic [11:0] det_cx,
  input  logic [11:0] det_cy,
  input  logic [11:0] det_w,
  input  logic [11:0] det_h,
  output logic [1:0]  lock_state,
  output logic        update,
  output logic        box_valid,
  output logic [11:0] center_x,
  output logic [11:0] center_y,
  output logic [11:0] box_x0,
  output logic [11:0] box_y0,
  output logic [11:0] box_x1,
  output logic [11:0] box_y1,
  output logic [12:0] err_x,
  output logic [12:0] err_y
);

  localparam int HW = $clog2(ACQ_FRAMES + 1);
  // one spare count so a miss counter sitting at LOST_FRAMES can still step once without wrapping
  localparam int MW = $clog2(LOST_FRAMES + 2);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_COAST   = 2'd3
  } state_t;

  function automatic logic [11:0] smooth_step(input logic [11:0] cur, input logic [11:0] tgt);
    logic signed [12:0] diff;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    diff = diff >>> 2;
    return cur + diff[11:0];
  endfunction

  function automatic logic [11:0] lo_clamp(input logic [11:0] c, input logic [11:0] s);
    logic signed [12:0] t;
    t = $signed({1'b0, c}) - $signed({2'b00, s[11:1]});
    if (t < 13'sd0) return 12'd0;
    else return t[11:0];
  endfunction

  function automatic logic [11:0] hi_clamp(input logic [11:0] c, input logic [11:0] s,
                                           input logic [11:0] lim);
    logic [12:0] t;
    t = {1'b0, c} + {2'b00, s[11:1]};
    if (t > {1'b0, lim}) return lim;
    else return t[11:0];
  endfunction

  function automatic logic is_near(input logic [11:0] a, input logic [11:0] b);
    logic signed [12:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    if (d < 13'sd0) d = -d;
    else d = d;
    return d <= $signed(13'(MAX_JUMP));
  endfunction

  state_t          state_r, state_s;
  logic [HW-1:0]   hit_cnt_r, hit_cnt_s, hit_inc_s;
  logic [MW-1:0]   miss_r, miss_s, miss_inc_s;
  logic            pend_r, pend_s;
  logic [11:0]     lat_cx_r, lat_cy_r, lat_w_r, lat_h_r;
  logic [11:0]     lat_cx_s, lat_cy_s, lat_w_s, lat_h_s;
  logic [11:0]     ref_x_r, ref_y_r, ref_x_s, ref_y_s;
  logic [11:0]     center_x_r, center_y_r, center_x_s, center_y_s;
  logic [11:0]     size_w_r, size_h_r, size_w_s, size_h_s;
  logic            update_r, update_s;
  logic            box_valid_r, box_valid_s;
  logic [11:0]     d_cx_s, d_cy_s, d_w_s, d_h_s, rx_s, ry_s;
  logic            d_pend_s, qual_s, good_s;
  logic [12:0]     err_x_s, err_y_s;

  // A detection arriving with frame_done belongs to the frame being closed, so bypass the latch.
  assign d_cx_s   = det_valid ? det_cx : lat_cx_r;
  assign d_cy_s   = det_valid ? det_cy : lat_cy_r;
  assign d_w_s    = det_valid ? det_w  : lat_w_r;
  assign d_h_s    = det_valid ? det_h  : lat_h_r;
  assign d_pend_s = det_valid | pend_r;
  assign rx_s     = (state_r == ST_ACQUIRE) ? ref_x_r : center_x_r;
  assign ry_s     = (state_r == ST_ACQUIRE) ? ref_y_r : center_y_r;
  assign qual_s   = d_pend_s && (d_w_s >= 12'(MIN_SIZE)) && (d_h_s >= 12'(MIN_SIZE));
  assign good_s   = qual_s && ((state_r == ST_SEARCH) ||
                               (is_near(d_cx_s, rx_s) && is_near(d_cy_s, ry_s)));
  assign hit_inc_s  = hit_cnt_r + HW'(1);
  assign miss_inc_s = miss_r + MW'(1);

  // Next-state, tracking and detection-latch update.
  always_comb begin
    state_s    = state_r;
    hit_cnt_s  = hit_cnt_r;
    miss_s     = miss_r;
    pend_s     = pend_r;
    lat_cx_s   = lat_cx_r;
    lat_cy_s   = lat_cy_r;
    lat_w_s    = lat_w_r;
    lat_h_s    = lat_h_r;
    ref_x_s    = ref_x_r;
    ref_y_s    = ref_y_r;
    center_x_s = center_x_r;
    center_y_s = center_y_r;
    size_w_s   = size_w_r;
    size_h_s   = size_h_r;
    update_s   = 1'b0;
    if (det_valid) begin
      pend_s   = 1'b1;
      lat_cx_s = det_cx;
      lat_cy_s = det_cy;
      lat_w_s  = det_w;
      lat_h_s  = det_h;
    end else begin
      pend_s = pend_r;
    end
    if (!enable) begin
      state_s    = ST_SEARCH;
      hit_cnt_s  = '0;
      miss_s     = '0;
      pend_s     = 1'b0;
      ref_x_s    = 12'd0;
      ref_y_s    = 12'd0;
      center_x_s = 12'd0;
      center_y_s = 12'd0;
      size_w_s   = 12'd0;
      size_h_s   = 12'd0;
    end else if (frame_done) begin
      update_s = 1'b1;
      pend_s   = 1'b0;
      case (state_r)
        ST_SEARCH: begin
          if (good_s) begin
            state_s   = ST_ACQUIRE;
            hit_cnt_s = HW'(1);
            ref_x_s   = d_cx_s;
            ref_y_s   = d_cy_s;
          end else begin
            hit_cnt_s = '0;
          end
        end
        ST_ACQUIRE: begin
          if (good_s) begin
            hit_cnt_s = hit_inc_s;
            ref_x_s   = d_cx_s;
            ref_y_s   = d_cy_s;
            if (hit_inc_s == HW'(ACQ_FRAMES)) begin
              state_s    = ST_LOCKED;
              center_x_s = d_cx_s;
              center_y_s = d_cy_s;
              size_w_s   = d_w_s;
              size_h_s   = d_h_s;
            end else begin
              state_s = ST_ACQUIRE;
            end
          end else begin
            state_s   = ST_SEARCH;
            hit_cnt_s = '0;
          end
        end
        ST_LOCKED, ST_COAST: begin
          if (good_s) begin
            state_s    = ST_LOCKED;
            center_x_s = smooth_step(center_x_r, d_cx_s);
            center_y_s = smooth_step(center_y_r, d_cy_s);
            size_w_s   = d_w_s;
            size_h_s   = d_h_s;
            miss_s     = '0;
          end else if (state_r == ST_LOCKED) begin
            state_s = ST_COAST;
            miss_s  = MW'(1);
          end else if (miss_inc_s >= MW'(LOST_FRAMES)) begin
            state_s    = ST_SEARCH;
            center_x_s = 12'd0;
            center_y_s = 12'd0;
            size_w_s   = 12'd0;
            size_h_s   = 12'd0;
            miss_s     = '0;
          end else begin
            miss_s = miss_inc_s;
          end
        end
        default: begin
          state_s = ST_SEARCH;
        end
      endcase
    end else begin
      update_s = 1'b0;
    end
  end

  assign box_valid_s = (state_s == ST_LOCKED) || (state_s == ST_COAST);

  // State and tracking registers.
  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_SEARCH;
      hit_cnt_r   <= '0;
      miss_r      <= '0;
      pend_r      <= 1'b0;
      lat_cx_r    <= 12'd0;
      lat_cy_r    <= 12'd0;
      lat_w_r     <= 12'd0;
      lat_h_r     <= 12'd0;
      ref_x_r     <= 12'd0;
      ref_y_r     <= 12'd0;
      center_x_r  <= 12'd0;
      center_y_r  <= 12'd0;
      size_w_r    <= 12'd0;
      size_h_r    <= 12'd0;
      update_r    <= 1'b0;
      box_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      hit_cnt_r   <= hit_cnt_s;
      miss_r      <= miss_s;
      pend_r      <= pend_s;
      lat_cx_r    <= lat_cx_s;
      lat_cy_r    <= lat_cy_s;
      lat_w_r     <= lat_w_s;
      lat_h_r     <= lat_h_s;
      ref_x_r     <= ref_x_s;
      ref_y_r     <= ref_y_s;
      center_x_r  <= center_x_s;
      center_y_r  <= center_y_s;
      size_w_r    <= size_w_s;
      size_h_r    <= size_h_s;
      update_r    <= update_s;
      box_valid_r <= box_valid_s;
    end
  end

  assign err_x_s = {1'b0, center_x_r} - 13'(WIDTH / 2);
  assign err_y_s = {1'b0, center_y_r} - 13'(HEIGHT / 2);

  assign lock_state = state_r;
  assign update     = update_r;
  assign box_valid  = box_valid_r;
  assign center_x   = center_x_r;
  assign center_y   = center_y_r;
  assign box_x0     = lo_clamp(center_x_r, size_w_r);
  assign box_y0     = lo_clamp(center_y_r, size_h_r);
  assign box_x1     = hi_clamp(center_x_r, size_w_r, 12'(WIDTH - 1));
  assign box_y1     = hi_clamp(center_y_r, size_h_r, 12'(HEIGHT - 1));
  // The error would otherwise read -WIDTH/2 while held in reset.
  assign err_x      = reset ? err_x_s : 13'd0;
  assign err_y      = reset ? err_y_s : 13'd0;

endmodule

// File: tb/tb_track_lock_ctrl.sv
// Bench for track_lock_ctrl: frame-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_track_lock_ctrl;

  logic        clock_50, reset, enable, frame_done, det_valid;
  logic [11:0] det_cx, det_cy, det_w, det_h;
  logic [1:0]  lock_state;
  logic        update, box_valid;
  logic [11:0] center_x, center_y, box_x0, box_y0, box_x1, box_y1;
  logic [12:0] err_x, err_y;

  int total = 0;
  int bad   = 0;

  // frame-level reference model state
  int m_st = 0, m_hits = 0, m_miss = 0, m_pend = 0, m_upd = 0;
  int l_cx = 0, l_cy = 0, l_w = 0, l_h = 0;
  int r_x = 0, r_y = 0, m_cx = 0, m_cy = 0, m_w = 0, m_h = 0;

  track_lock_ctrl dut (
    .clock_50  (clock_50),
    .reset     (reset),
    .enable    (enable),
    .frame_done(frame_done),
    .det_valid (det_valid),
    .det_cx    (det_cx),
    .det_cy    (det_cy),
    .det_w     (det_w),
    .det_h     (det_h),
    .lock_state(lock_state),
    .update    (update),
    .box_valid (box_valid),
    .center_x  (center_x),
    .center_y  (center_y),
    .box_x0    (box_x0),
    .box_y0    (box_y0),
    .box_x1    (box_x1),
    .box_y1    (box_y1),
    .err_x     (err_x),
    .err_y     (err_y)
  );

  initial begin
    clock_50 = 1'b0;
    forever #5 clock_50 = ~clock_50;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // floor(v/4) for either sign
  function automatic int floor4(input int v);
    if (v >= 0) return v / 4;
    else return -((-v + 3) / 4);
  endfunction

  function automatic void model_clear();
    m_st = 0; m_hits = 0; m_miss = 0; m_pend = 0;
    r_x = 0; r_y = 0; m_cx = 0; m_cy = 0; m_w = 0; m_h = 0;
  endfunction

  // Reference model: one step per clock, frame processed whenever frame_done is seen.
  initial begin
    int good;
    forever begin
      @(posedge clock_50 or negedge reset);
      m_upd = 0;
      if (reset !== 1'b1) begin
        model_clear();
      end else if (!enable) begin
        model_clear();
      end else begin
        if (det_valid) begin
          m_pend = 1; l_cx = det_cx; l_cy = det_cy; l_w = det_w; l_h = det_h;
        end
        if (frame_done) begin
          m_upd = 1;
          good = (m_pend == 1 && l_w >= 4 && l_h >= 4) ? 1 : 0;
          if (m_st == 1)
            good = good && iabs(l_cx - r_x) <= 64 && iabs(l_cy - r_y) <= 64;
          else if (m_st >= 2)
            good = good && iabs(l_cx - m_cx) <= 64 && iabs(l_cy - m_cy) <= 64;
          if (m_st == 0) begin
            if (good) begin m_st = 1; m_hits = 1; r_x = l_cx; r_y = l_cy; end
          end else if (m_st == 1) begin
            if (good) begin
              m_hits++; r_x = l_cx; r_y = l_cy;
              if (m_hits == 3) begin m_st = 2; m_cx = l_cx; m_cy = l_cy; m_w = l_w; m_h = l_h; end
            end else begin
              m_st = 0; m_hits = 0;
            end
          end else if (good) begin
            m_st = 2; m_miss = 0;
            m_cx = m_cx + floor4(l_cx - m_cx);
            m_cy = m_cy + floor4(l_cy - m_cy);
            m_w = l_w; m_h = l_h;
          end else begin
            m_st = 3; m_miss++;
            if (m_miss == 8) begin
              m_st = 0; m_miss = 0; m_cx = 0; m_cy = 0; m_w = 0; m_h = 0;
            end
          end
          m_pend = 0;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    int ex0, ex1, ey0, ey1;
    forever begin
      @(negedge clock_50);
      #1;
      ex0 = (m_cx - m_w / 2 < 0) ? 0 : m_cx - m_w / 2;
      ey0 = (m_cy - m_h / 2 < 0) ? 0 : m_cy - m_h / 2;
      ex1 = (m_cx + m_w / 2 > 639) ? 639 : m_cx + m_w / 2;
      ey1 = (m_cy + m_h / 2 > 479) ? 479 : m_cy + m_h / 2;
      chk("cmp_state", int'(lock_state), m_st);
      chk("cmp_update", int'(update), m_upd);
      chk("cmp_box_valid", int'(box_valid), (m_st >= 2) ? 1 : 0);
      chk("cmp_center_x", int'(center_x), m_cx);
      chk("cmp_center_y", int'(center_y), m_cy);
      chk("cmp_box_x0", int'(box_x0), ex0);
      chk("cmp_box_y0", int'(box_y0), ey0);
      chk("cmp_box_x1", int'(box_x1), ex1);
      chk("cmp_box_y1", int'(box_y1), ey1);
      chk("cmp_err_x", int'($signed(err_x)), (reset === 1'b1) ? m_cx - 320 : 0);
      chk("cmp_err_y", int'($signed(err_y)), (reset === 1'b1) ? m_cy - 240 : 0);
    end
  end

  task automatic det(input int cx, input int cy, input int w, input int h);
    @(negedge clock_50);
    det_valid = 1'b1;
    det_cx = 12'(cx); det_cy = 12'(cy); det_w = 12'(w); det_h = 12'(h);
    @(negedge clock_50);
    det_valid = 1'b0;
  endtask

  task automatic fd();
    @(negedge clock_50);
    frame_done = 1'b1;
    @(negedge clock_50);
    frame_done = 1'b0;
  endtask

  task automatic frame_with_det(input int cx, input int cy, input int w, input int h);
    @(negedge clock_50);
    frame_done = 1'b1; det_valid = 1'b1;
    det_cx = 12'(cx); det_cy = 12'(cy); det_w = 12'(w); det_h = 12'(h);
    @(negedge clock_50);
    frame_done = 1'b0; det_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; frame_done = 1'b0; det_valid = 1'b0;
    det_cx = 12'd0; det_cy = 12'd0; det_w = 12'd0; det_h = 12'd0;

    // reset held with frame_done toggling and a detection present
    for (int i = 0; i < 6; i++) begin
      @(negedge clock_50);
      frame_done = (i % 2 == 0) ? 1'b1 : 1'b0;
      det_valid = (i == 2) ? 1'b1 : 1'b0;
      det_cx = 12'd320; det_cy = 12'd240; det_w = 12'd40; det_h = 12'd30;
      #2;
      chk("rst_update", int'(update), 0);
      chk("rst_state", int'(lock_state), 0);
      chk("rst_err_x", int'($signed(err_x)), 0);
    end
    @(negedge clock_50);
    frame_done = 1'b0; det_valid = 1'b0;
    #1 reset = 1'b1;
    #1 chk("post_rst_err_x", int'($signed(err_x)), -320);

    // acquire
    for (int i = 0; i < 3; i++) begin
      det(320, 240, 40, 30);
      fd();
      chk("acq_update", int'(update), 1);
      chk("acq_state", int'(lock_state), (i < 2) ? 1 : 2);
    end
    chk("acq_cx", int'(center_x), 320);
    chk("acq_cy", int'(center_y), 240);
    chk("acq_x0", int'(box_x0), 300);
    chk("acq_y0", int'(box_y0), 225);
    chk("acq_x1", int'(box_x1), 340);
    chk("acq_y1", int'(box_y1), 255);
    chk("acq_errx", int'($signed(err_x)), 0);
    chk("acq_erry", int'($signed(err_y)), 0);
    chk("acq_bv", int'(box_valid), 1);
    @(negedge clock_50);
    chk("upd_one_cycle", int'(update), 0);

    // jump then smoothing
    det(400, 240, 40, 30); fd();
    chk("jump_state", int'(lock_state), 3);
    chk("jump_cx", int'(center_x), 320);
    det(340, 240, 40, 30); fd();
    chk("relock_state", int'(lock_state), 2);
    chk("smooth_up_cx", int'(center_x), 325);
    det(305, 240, 40, 30); fd();
    chk("smooth_dn_cx", int'(center_x), 320);

    // loss over 8 empty frames
    for (int i = 0; i < 8; i++) begin
      fd();
      if (i == 0) chk("loss_first_state", int'(lock_state), 3);
    end
    chk("loss_state", int'(lock_state), 0);
    chk("loss_bv", int'(box_valid), 0);
    chk("loss_cx", int'(center_x), 0);

    // clamp at frame corner
    for (int i = 0; i < 3; i++) begin
      det(10, 470, 40, 40); fd();
    end
    chk("clamp_state", int'(lock_state), 2);
    chk("clamp_x0", int'(box_x0), 0);
    chk("clamp_y0", int'(box_y0), 450);
    chk("clamp_x1", int'(box_x1), 30);
    chk("clamp_y1", int'(box_y1), 479);
    chk("clamp_errx", int'($signed(err_x)), -310);
    chk("clamp_erry", int'($signed(err_y)), 230);

    // enable low while locked
    @(negedge clock_50);
    enable = 1'b0;
    @(negedge clock_50);
    chk("dis_state", int'(lock_state), 0);
    chk("dis_cx", int'(center_x), 0);
    fd();
    chk("dis_update", int'(update), 0);
    enable = 1'b1;

    // detection coincident with frame_done
    for (int i = 0; i < 3; i++) frame_with_det(320, 240, 40, 30);
    chk("coinc_state", int'(lock_state), 2);

    // undersized detection is a miss
    det(320, 240, 3, 30); fd();
    chk("small_state", int'(lock_state), 3);
    det(320, 240, 40, 30); fd();
    chk("small_relock", int'(lock_state), 2);

    // two detections in one frame: last wins
    det(500, 240, 40, 30);
    det(330, 240, 40, 30);
    fd();
    chk("last_wins_state", int'(lock_state), 2);
    chk("last_wins_cx", int'(center_x), 322);

    // back-to-back frame_done: second frame has no detection
    @(negedge clock_50);
    frame_done = 1'b1; det_valid = 1'b1;
    det_cx = 12'd322; det_cy = 12'd240; det_w = 12'd40; det_h = 12'd30;
    @(negedge clock_50);
    det_valid = 1'b0;
    chk("b2b_first_state", int'(lock_state), 2);
    @(negedge clock_50);
    frame_done = 1'b0;
    chk("b2b_second_state", int'(lock_state), 3);
    chk("b2b_update", int'(update), 1);

    // asynchronous reset mid-frame drops the pending detection
    det(322, 240, 40, 30);
    @(negedge clock_50);
    #3 reset = 1'b0;
    #1 chk("async_state", int'(lock_state), 0);
    @(negedge clock_50);
    #1 reset = 1'b1;
    fd();
    chk("async_after_state", int'(lock_state), 0);
    chk("async_after_update", int'(update), 1);

    repeat (3) @(negedge clock_50);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
